sudoku_recognize_scheduler: RTL and testbench

Top-level recognition sequencer for the handwritten-sudoku flow. It walks the 81 grid cells in row-major order and fetches each 52×52 cell image from the cell-image store through a request/valid handshake. Blank cells are resolved locally; every other cell runs through the digit predictor. The results are assembled into a 9×9 board register for the solver and display.

---
 rtl/sudoku_recognize_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_sudoku_recognize_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_recognize_scheduler.sv
// Recognition sequencer: walks the 81 sudoku cells, fetches each image from
// the cell store, skips near-empty cells, runs the rest through the digit
// predictor and assembles the results into a 9x9 board register.
module sudoku_recognize_scheduler #(
    parameter int CELLS   = 81,
    parameter int PIX     = 2704,
    parameter int MIN_INK = 40,
    parameter int TIMEOUT = 4095
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [CELLS*4-1:0] board,
    output logic               board_valid,
    output logic               timeout_err,
    output logic [6:0]         cell_idx,
    output logic               cell_req,
    input  logic               cell_valid,
    input  logic [PIX-1:0]     cell_img,
    output logic               pred_start,
    output logic [PIX-1:0]     pred_img,
    input  logic [3:0]         pred_number,
    input  logic               pred_finish
);

    localparam int INKW = $clog2(PIX + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_CHECK  = 3'd2,
        S_LAUNCH = 3'd3,
        S_WAIT   = 3'd4,
        S_STORE  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Number of ink pixels in a cell image.
    function automatic logic [INKW-1:0] popcount(input logic [PIX-1:0] img);
        logic [INKW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PIX; i++) begin
            cnt = cnt + INKW'(img[i]);
        end
        return cnt;
    endfunction

    state_t             state_q, state_d;
    logic [6:0]         cell_idx_q, cell_idx_d;
    logic [CELLS*4-1:0] board_q, board_d;
    logic               board_valid_q, board_valid_d;
    logic               timeout_err_q, timeout_err_d;
    logic [PIX-1:0]     pred_img_q, pred_img_d;
    logic [3:0]         digit_q, digit_d;
    logic [TW-1:0]      wait_q, wait_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cell_req_q, cell_req_d;
    logic               pred_start_q, pred_start_d;
    logic [INKW-1:0]    ink_s;

    // Ink count of the image currently held for the predictor.
    always_comb begin
        ink_s = popcount(pred_img_q);
    end

    // Next-state logic; strobes are derived from the next state so they are registered.
    always_comb begin
        state_d       = state_q;
        cell_idx_d    = cell_idx_q;
        board_d       = board_q;
        board_valid_d = board_valid_q;
        timeout_err_d = timeout_err_q;
        pred_img_d    = pred_img_q;
        digit_d       = digit_q;
        wait_d        = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_REQ;
                    cell_idx_d    = 7'd0;
                    timeout_err_d = 1'b0;
                    board_valid_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (cell_valid) begin
                    pred_img_d = cell_img;
                    state_d    = S_CHECK;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_CHECK: begin
                if (ink_s < INKW'(MIN_INK)) begin
                    digit_d = 4'd0;
                    state_d = S_STORE;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q + TW'(1);
                // A finish in the timeout cycle still delivers its digit.
                if (pred_finish) begin
                    digit_d = (pred_number > 4'd9) ? 4'd0 : pred_number;
                    state_d = S_STORE;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    digit_d       = 4'd0;
                    timeout_err_d = 1'b1;
                    state_d       = S_STORE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_STORE: begin
                board_d[int'(cell_idx_q)*4 +: 4] = digit_q;
                if (cell_idx_q == 7'(CELLS - 1)) begin
                    board_valid_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    cell_idx_d = cell_idx_q + 7'd1;
                    state_d    = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        cell_req_d   = (state_d == S_REQ);
        pred_start_d = (state_d == S_LAUNCH);
    end

    // State and output registers; reset aborts any scan immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cell_idx_q    <= 7'd0;
            board_q       <= '0;
            board_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
            pred_img_q    <= '0;
            digit_q       <= 4'd0;
            wait_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cell_req_q    <= 1'b0;
            pred_start_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cell_idx_q    <= cell_idx_d;
            board_q       <= board_d;
            board_valid_q <= board_valid_d;
            timeout_err_q <= timeout_err_d;
            pred_img_q    <= pred_img_d;
            digit_q       <= digit_d;
            wait_q        <= wait_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cell_req_q    <= cell_req_d;
            pred_start_q  <= pred_start_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign board       = board_q;
    assign board_valid = board_valid_q;
    assign timeout_err = timeout_err_q;
    assign cell_idx    = cell_idx_q;
    assign cell_req    = cell_req_q;
    assign pred_start  = pred_start_q;
    assign pred_img    = pred_img_q;

endmodule

// File: tb/tb_sudoku_recognize_scheduler.sv
// Table-driven bench for sudoku_recognize_scheduler with behavioural
// cell-store (latency 1) and predictor (latency 6) models.
module tb_sudoku_recognize_scheduler;

    localparam int CELLS   = 81;
    localparam int PIX     = 2704;
    localparam int MIN_INK = 40;
    localparam int TOUT    = 20;
    localparam int PLAT    = 6;
    localparam int BW      = CELLS * 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic           busy;
    logic           done;
    logic [BW-1:0]  board;
    logic           board_valid;
    logic           timeout_err;
    logic [6:0]     cell_idx;
    logic           cell_req;
    logic           cell_valid;
    logic [PIX-1:0] cell_img;
    logic           pred_start;
    logic [PIX-1:0] pred_img;
    logic [3:0]     pred_number;
    logic           pred_finish;

    sudoku_recognize_scheduler #(
        .CELLS(CELLS), .PIX(PIX), .MIN_INK(MIN_INK), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .board(board), .board_valid(board_valid), .timeout_err(timeout_err),
        .cell_idx(cell_idx), .cell_req(cell_req), .cell_valid(cell_valid),
        .cell_img(cell_img), .pred_start(pred_start), .pred_img(pred_img),
        .pred_number(pred_number), .pred_finish(pred_finish)
    );

    typedef struct {
        string nm;
        int    ink_mode;    // 0 all blank, 1 all 100 px, 2 cell0=39 cell1=40 rest blank
        int    hang;        // cell whose predictor never finishes, -1 none
        int    ovr_idx;     // cell whose predictor returns ovr_val
        int    ovr_val;
        int    extra_start; // cell in whose WAIT a second start is pulsed, -1 none
        int    exp_cycles;  // start edge to done
        int    exp_preds;
        int    exp_terr;
    } scen_t;

    int ink_tab [CELLS];
    int pval    [CELLS];
    int hang_idx;
    int ps_cnt;
    int done_cnt;
    int n_cmp;
    int n_bad;

    always #5 clk = ~clk;

    function automatic logic [PIX-1:0] make_img(input int n);
        logic [PIX-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int ink_of(input int mode, input int k);
        if (mode == 1) return 100;
        if (mode == 2) return (k == 0) ? 39 : ((k == 1) ? 40 : 0);
        return 0;
    endfunction

    function automatic logic [BW-1:0] exp_board(input scen_t s);
        logic [BW-1:0] b;
        int v;
        b = '0;
        for (int k = 0; k < CELLS; k++) begin
            v = (k == s.ovr_idx) ? s.ovr_val : (k % 9) + 1;
            if (ink_of(s.ink_mode, k) < MIN_INK || k == s.hang || v > 9) v = 0;
            b[4*k +: 4] = 4'(v);
        end
        return b;
    endfunction

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, BW'(busy), '0);
        check({tag, "_done"}, BW'(done), '0);
        check({tag, "_board_valid"}, BW'(board_valid), '0);
        check({tag, "_timeout_err"}, BW'(timeout_err), '0);
        check({tag, "_cell_req"}, BW'(cell_req), '0);
        check({tag, "_pred_start"}, BW'(pred_start), '0);
        check({tag, "_cell_idx"}, BW'(cell_idx), '0);
        check({tag, "_board"}, board, '0);
        check({tag, "_pred_img_nz"}, BW'(pred_img != '0), '0);
    endtask

    task automatic setup(input scen_t s);
        for (int k = 0; k < CELLS; k++) begin
            ink_tab[k] = ink_of(s.ink_mode, k);
            pval[k]    = (k == s.ovr_idx) ? s.ovr_val : (k % 9) + 1;
        end
        hang_idx = s.hang;
    endtask

    task automatic run_scen(input scen_t s);
        int n;
        int ps0;
        int dn0;
        bit pulsed;
        logic prev_ps;
        setup(s);
        ps0 = ps_cnt;
        dn0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({s.nm, "_first_idx"}, BW'(cell_idx), '0);
        check({s.nm, "_first_req"}, BW'(cell_req), BW'(1));
        check({s.nm, "_busy"}, BW'(busy), BW'(1));
        check({s.nm, "_bv_cleared"}, BW'(board_valid), '0);
        n = 0;
        pulsed = 1'b0;
        prev_ps = 1'b0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (s.extra_start >= 0 && prev_ps && int'(cell_idx) == s.extra_start && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            prev_ps = pred_start;
        end
        start = 1'b0;
        check({s.nm, "_done_seen"}, BW'(done), BW'(1));
        check({s.nm, "_cycles"}, BW'(n), BW'(s.exp_cycles));
        check({s.nm, "_board_valid"}, BW'(board_valid), BW'(1));
        check({s.nm, "_timeout_err"}, BW'(timeout_err), BW'(s.exp_terr));
        check({s.nm, "_board"}, board, exp_board(s));
        repeat (3) @(posedge clk);
        #1;
        check({s.nm, "_idle_busy"}, BW'(busy), '0);
        check({s.nm, "_idle_req"}, BW'(cell_req), '0);
        check({s.nm, "_bv_held"}, BW'(board_valid), BW'(1));
        check({s.nm, "_done_pulses"}, BW'(done_cnt - dn0), BW'(1));
        check({s.nm, "_pred_starts"}, BW'(ps_cnt - ps0), BW'(s.exp_preds));
    endtask

    // Cell store: answers a request one cycle after it is raised.
    initial begin
        cell_valid = 1'b0;
        cell_img   = '0;
        forever begin
            @(negedge clk);
            if (cell_req && !cell_valid) begin
                cell_valid = 1'b1;
                cell_img   = make_img(ink_tab[cell_idx]);
            end else begin
                cell_valid = 1'b0;
            end
        end
    end

    // Predictor: finish PLAT cycles after pred_start, unless the cell hangs.
    initial begin
        int cnt;
        int cur;
        bit pend;
        pred_finish = 1'b0;
        pred_number = 4'd0;
        ps_cnt = 0;
        done_cnt = 0;
        pend = 1'b0;
        cnt = 0;
        cur = 0;
        forever begin
            @(negedge clk);
            pred_finish = 1'b0;
            if (done) done_cnt++;
            if (pred_start) begin
                ps_cnt++;
                cur  = int'(cell_idx);
                cnt  = PLAT;
                pend = (cur != hang_idx);
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pred_finish = 1'b1;
                    pred_number = 4'(pval[cur]);
                    pend = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl [5];
        int w;
        tbl[0] = '{"blank",   0, -1, -1, 0, -1, 243, 0,  0};
        tbl[1] = '{"inked",   1, -1, -1, 0, -1, 810, 81, 0};
        tbl[2] = '{"timeout", 1, 40, -1, 0, -1, 824, 81, 1};
        tbl[3] = '{"minink",  2, -1, -1, 0, -1, 250, 1,  0};
        tbl[4] = '{"restart", 1, -1,  5, 12, 5, 810, 81, 0};
        n_cmp = 0;
        n_bad = 0;
        hang_idx = -1;
        for (int k = 0; k < CELLS; k++) begin
            ink_tab[k] = 0;
            pval[k] = 0;
        end
        clk = 1'b0;
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_scen(tbl[i]);

        // Abort mid-scan: reset during WAIT of cell 30.
        setup(tbl[1]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!(int'(cell_idx) == 30 && pred_start) && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        check("abort_reached_cell30", BW'(cell_idx), BW'(30));
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_reset_vals("abort");
        repeat (3) @(posedge clk);
        #1;
        check("abort_held_busy", BW'(busy), '0);
        check("abort_no_done", BW'(done), '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_scen('{"after_abort", 0, -1, -1, 0, -1, 243, 0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
